// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - sizing, flush sequencing and position tracking for the line-delay FIFO
// Frame FSM: IDLE -> FLUSH (2 cycles) -> MEASURE (auto width) -> RUN.
module line_buffer_ctrl #(
  parameter int MAX_WIDTH    = 4096,
  parameter int DEFAULT_SIZE = 640,
  parameter int PRIME_LINES  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        in_valid,
  input  logic        cfg_auto,
  input  logic [15:0] cfg_width,
  output logic [15:0] fifo_size,
  output logic        fifo_enable,
  output logic        fifo_reset_n,
  output logic        window_valid,
  output logic [15:0] col_count,
  output logic [11:0] line_count,
  output logic        width_error,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    MEASURE = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam logic [15:0] MAX_W    = 16'(MAX_WIDTH);
  localparam logic [15:0] DEF_SIZE = 16'(DEFAULT_SIZE);
  localparam logic [11:0] PRIME    = 12'(PRIME_LINES);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic        auto_q, auto_d;
  logic [15:0] size_q, size_d;
  logic        rst_n_q, rst_n_d;
  logic [15:0] col_q, col_d;
  logic [11:0] line_q, line_d;
  logic        err_q, err_d;

  logic [15:0] col_inc;
  logic        line_end;

  function automatic logic [15:0] clamp_width(input logic [15:0] w);
    if (w < 16'd2) begin
      return 16'd2;
    end else if (w > MAX_W) begin
      return MAX_W;
    end
    return w;
  endfunction

  function automatic logic out_of_range(input logic [15:0] w);
    return (w < 16'd2) || (w > MAX_W);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      auto_q  <= 1'b0;
      size_q  <= DEF_SIZE;
      rst_n_q <= 1'b0;
      col_q   <= 16'd0;
      line_q  <= 12'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      auto_q  <= auto_d;
      size_q  <= size_d;
      rst_n_q <= rst_n_d;
      col_q   <= col_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = 1'b0;
    auto_d   = auto_q;
    size_d   = size_q;
    rst_n_d  = 1'b1;
    col_d    = col_q;
    line_d   = line_q;
    err_d    = err_q;
    col_inc  = (col_q == 16'hFFFF) ? col_q : col_q + 16'd1;
    line_end = !in_valid && (col_q != 16'd0);

    // frame_start pre-empts everything, including a line in progress.
    if (frame_start) begin
      state_d = FLUSH;
      rst_n_d = 1'b0;
      col_d   = 16'd0;
      line_d  = 12'd0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        FLUSH: begin
          if (!phase_q) begin
            phase_d = 1'b1;
            auto_d  = cfg_auto;
            if (!cfg_auto) begin
              size_d = clamp_width(cfg_width);
              if (out_of_range(cfg_width)) err_d = 1'b1;
            end
          end else begin
            state_d = auto_q ? MEASURE : RUN;
          end
        end
        MEASURE: begin
          if (in_valid) begin
            col_d = col_inc;
          end else if (line_end) begin
            size_d  = clamp_width(col_q);
            if (out_of_range(col_q)) err_d = 1'b1;
            col_d   = 16'd0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            col_d = col_inc;
          end else if (line_end) begin
            line_d = (line_q == 12'hFFF) ? line_q : line_q + 12'd1;
            if (col_q != size_q) err_d = 1'b1;
            col_d  = 16'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The FIFO writes the current pixel, so the enable is combinational.
  assign fifo_enable  = (state_q == RUN) && in_valid && !frame_start;
  assign window_valid = fifo_enable && (line_q >= PRIME);
  assign fifo_size    = size_q;
  assign fifo_reset_n = rst_n_q;
  assign col_count    = col_q;
  assign line_count   = line_q;
  assign width_error  = err_q;
  assign state        = state_q;

endmodule
